rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
- Sequencing controller and two-port arbiter for the 256x8 asynchronous ROM, which has combinational read, active-high ce/read_en and outputs 0 when disabled.
- Two requesters issue burst read commands (start address + length) through a valid/ready handshake.
- Block arbitrates round-robin, drives the ROM address/enables one address per cycle, and returns registered data beats with a last flag to the granted requester.

Parameters:
ADDR_W, 8, ROM address width; burst address wraps modulo 2^ADDR_W
DATA_W, 8, ROM data width
LEN_W, 4, burst length field width; burst = len+1 beats (1..2^LEN_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 command valid; held until req0_ready
req0_addr  in  ADDR_W  requester 0 start address
req0_len  in  LEN_W  requester 0 beats minus one
req0_ready  out  1  requester 0 command accepted this cycle
rsp0_valid  out  1  requester 0 data beat valid
rsp0_data  out  DATA_W  requester 0 data beat
rsp0_last  out  1  final beat of requester 0 burst
req1_valid, req1_addr, req1_len, req1_ready, rsp1_valid, rsp1_data, rsp1_last: same as port 0, for requester 1
rom_addr  out  ADDR_W  ROM address
rom_read_en  out  1  ROM read enable
rom_ce  out  1  ROM chip enable
rom_data  in  DATA_W  ROM data (combinational from rom_addr)
busy  out  1  high while a burst occupies the ROM

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rom_addr=0, rom_ce=rom_read_en=0, all rsp*_valid/last=0, rsp*_data=0, busy=0, round-robin pointer favours requester 0.
- States: IDLE, READ.
- IDLE: req*_ready is combinational; exactly one port is readied, chosen as follows.
  - Only one valid: that port.
  - Both valid: the port the pointer favours.
  - None valid: no ready.
- Acceptance: on valid&&ready, latch addr, len and grant id; remaining count=len; next state READ. Pointer then favours the other port.
- req*_ready is never high outside IDLE.
- READ, each cycle:
  - rom_ce=rom_read_en=1, rom_addr=current address, busy=1.
  - Next edge: rom_data registered into the granted port's rsp_data, and rsp_valid=1. rsp_last=1 when the count was 0.
  - Then address+1 (wraps 255->0), count-1.
  - When the count was 0, next state is IDLE.
- Latency: accept at cycle T; addresses driven T+1..T+1+len; beats on rsp at T+2..T+2+len. Exactly len+1 beats, in address order.
- Non-granted port's rsp_valid/last stay 0 and its rsp_data holds its previous value.
- Back-to-back: a new command may be accepted in the cycle the previous burst's last beat is on rsp. Gap between bursts on rom_ce is exactly one cycle.
- IDLE: rom_ce=rom_read_en=0, rom_addr holds its last value, busy=0, rsp*_valid=0.
- No response backpressure: requester must take every beat.
- Reset mid-burst: burst aborted immediately, no rsp_last emitted, state returns to IDLE.
- A valid dropped before ready is a protocol violation; behaviour is undefined and not checked.

Test Plan:
- ROM mem[0x10]=0xA5. req0 addr=0x10 len=0 -> req0_ready at T; rom_addr=0x10 with rom_ce=1 at T+1; rsp0_valid=1, rsp0_data=0xA5, rsp0_last=1 at T+2; rsp1_valid stays 0.
- Wrap burst: req1 addr=0xFE len=3 -> rom_addr sequence FE,FF,00,01; four rsp1 beats of mem[FE],mem[FF],mem[00],mem[01]; last beat only on the 4th.
- Simultaneous: req0 and req1 valid in the same cycle after reset, both len=1 -> req0 granted first; req1 granted in the cycle of req0's last beat; then both valid again -> req0 granted next.
- Max burst: addr=0x00 len=15 -> 16 beats mem[00..0F]; busy high for 16 cycles; rom_ce low in IDLE before and after.
- Reset: rst_n=0 on the 3rd address cycle of a len=7 burst -> all outputs 0 asynchronously, no rsp_last; after release, req1 addr=0x20 len=0 returns mem[0x20] normally.

Source files
------------

// File: rtl/rom_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rom_read_arbiter
// Brief   : Round-robin two-port burst reader for a combinational 256x8 ROM.
// Rev     : 1.0 - initial release
// ============================================================================
module rom_read_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_len,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_last,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_last,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read_en,
  output logic              rom_ce,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_gnt;
  logic              r_ptr;
  logic              w_sel;
  logic              w_accept;

  // Pointer only matters on contention; a lone requester is always served.
  assign w_sel    = (req0_valid && req1_valid) ? r_ptr : req1_valid;
  assign rom_addr = r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rom_ce      = 1'b0;
    rom_read_en = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_ready = req0_valid && !w_sel;
        req1_ready = req1_valid && w_sel;
        w_accept   = req0_ready || req1_ready;
        if (w_accept) w_state_nxt = S_READ;
      end
      S_READ: begin
        rom_ce      = 1'b1;
        rom_read_en = 1'b1;
        busy        = 1'b1;
        if (r_cnt == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_cnt      <= '0;
      r_gnt      <= 1'b0;
      r_ptr      <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_last  <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_last  <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp0_last  <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_last  <= 1'b0;
      if (w_accept) begin
        r_addr <= w_sel ? req1_addr : req0_addr;
        r_cnt  <= w_sel ? req1_len  : req0_len;
        r_gnt  <= w_sel;
        r_ptr  <= ~w_sel;
      end else if (r_state == S_READ) begin
        if (r_gnt) begin
          rsp1_valid <= 1'b1;
          rsp1_data  <= rom_data;
          rsp1_last  <= (r_cnt == '0);
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_data  <= rom_data;
          rsp0_last  <= (r_cnt == '0);
        end
        // Address freezes on the final beat so it holds in IDLE.
        if (r_cnt != '0) begin
          r_addr <= r_addr + ADDR_W'(1);
          r_cnt  <= r_cnt - LEN_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_read_arbiter.sv
`default_nettype none
// Self-checking bench for rom_read_arbiter: ROM model plus per-port scoreboard queues.
module tb_rom_read_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, rsp0_valid, rsp0_last;
  logic [7:0] req0_addr, rsp0_data;
  logic [3:0] req0_len;
  logic       req1_valid, req1_ready, rsp1_valid, rsp1_last;
  logic [7:0] req1_addr, rsp1_data;
  logic [3:0] req1_len;
  logic [7:0] rom_addr, rom_data;
  logic       rom_read_en, rom_ce, busy;

  logic [7:0] mem [256];
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rom_data = (rom_ce && rom_read_en) ? mem[rom_addr] : 8'h00;

  rom_read_arbiter #(.ADDR_W(8), .DATA_W(8), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_last(rsp0_last),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_last(rsp1_last),
    .rom_addr(rom_addr), .rom_read_en(rom_read_en), .rom_ce(rom_ce), .rom_data(rom_data),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int p, input logic [7:0] a, input logic [3:0] l);
    int len;
    logic [7:0] ad;
    len = int'(l);
    for (int i = 0; i <= len; i++) begin
      ad = a + 8'(i);
      if (p == 0) q0.push_back({(i == len), mem[ad]});
      else        q1.push_back({(i == len), mem[ad]});
    end
  endtask

  // Waits (bounded) for a ready; samples on the falling edge.
  task automatic wait_acc(output int who);
    who = -1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        chk("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        who = req0_ready ? 0 : 1;
        return;
      end
      @(posedge clk);
    end
    chk("ready_timeout", 32'd1, 32'd0);
  endtask

  task automatic accept(input int who);
    if (who == 0) push_exp(0, req0_addr, req0_len);
    if (who == 1) push_exp(1, req1_addr, req1_len);
    @(posedge clk);
    #1;
    if (who == 0) req0_valid = 1'b0;
    if (who == 1) req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !busy) break;
    end
    chk("drain", q0.size() + q1.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic mon_port(input int p, input logic v, input logic [7:0] d, input logic l);
    logic [8:0] e;
    int sz;
    if (!v) return;
    sz = (p == 0) ? q0.size() : q1.size();
    chk(p == 0 ? "rsp0_expected" : "rsp1_expected", {31'd0, sz > 0}, 32'd1);
    if (sz > 0) begin
      e = (p == 0) ? q0.pop_front() : q1.pop_front();
      chk(p == 0 ? "rsp0_data" : "rsp1_data", {24'd0, d}, {24'd0, e[7:0]});
      chk(p == 0 ? "rsp0_last" : "rsp1_last", {31'd0, l}, {31'd0, e[8]});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_port(0, rsp0_valid, rsp0_data, rsp0_last);
      mon_port(1, rsp1_valid, rsp1_data, rsp1_last);
      if (busy) chk("ready_while_busy", {31'd0, req0_ready | req1_ready}, 32'd0);
    end
  end

  initial begin
    int who;
    int nbusy;
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) & 255);
    mem[8'h10] = 8'hA5;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_len = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_len = '0;
    #12;
    chk("rst_rom_ce", {31'd0, rom_ce}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp", {15'd0, rsp0_valid, rsp0_last, rsp0_data, rsp1_valid, rsp1_last, rsp1_data}, 32'd0);
    chk("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat read with latency checks
    req0_valid = 1'b1; req0_addr = 8'h10; req0_len = 4'd0;
    wait_acc(who);
    chk("t1_grant", who, 0);
    chk("t1_idle_ce", {31'd0, rom_ce}, 32'd0);
    accept(who);
    @(negedge clk);
    chk("t1_rom_addr", {24'd0, rom_addr}, 32'h10);
    chk("t1_rom_en", {30'd0, rom_ce, rom_read_en}, 32'd3);
    @(negedge clk);
    chk("t1_rsp0", {22'd0, rsp0_valid, rsp0_last, rsp0_data}, {22'd0, 2'b11, 8'hA5});
    chk("t1_rsp1_quiet", {31'd0, rsp1_valid}, 32'd0);
    drain();

    // Wrapping burst on port 1
    req1_valid = 1'b1; req1_addr = 8'hFE; req1_len = 4'd3;
    wait_acc(who);
    chk("t2_grant", who, 1);
    accept(who);
    drain();
    chk("t2_rsp0_hold", {24'd0, rsp0_data}, 32'hA5);

    // Contention: port 0 first, then port 1 on port 0's last beat
    req0_valid = 1'b1; req0_addr = 8'h30; req0_len = 4'd1;
    req1_valid = 1'b1; req1_addr = 8'h50; req1_len = 4'd1;
    wait_acc(who);
    chk("t3_first", who, 0);
    accept(who);
    wait_acc(who);
    chk("t3_second", who, 1);
    chk("t3_b2b_last", {30'd0, rsp0_valid, rsp0_last}, 32'd3);
    accept(who);
    req0_valid = 1'b1; req0_addr = 8'h70; req0_len = 4'd2;
    req1_valid = 1'b1; req1_addr = 8'h90; req1_len = 4'd0;
    wait_acc(who);
    chk("t3_third", who, 0);
    accept(who);
    wait_acc(who);
    chk("t3_fourth", who, 1);
    accept(who);
    drain();

    // Maximum-length burst
    req0_valid = 1'b1; req0_addr = 8'h00; req0_len = 4'd15;
    wait_acc(who);
    chk("t4_grant", who, 0);
    chk("t4_ce_before", {31'd0, rom_ce}, 32'd0);
    accept(who);
    nbusy = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    chk("t4_busy_cycles", nbusy, 16);
    chk("t4_ce_after", {31'd0, rom_ce}, 32'd0);
    drain();

    // Reset on the third address cycle of a len=7 burst
    req0_valid = 1'b1; req0_addr = 8'h40; req0_len = 4'd7;
    wait_acc(who);
    chk("t5_grant", who, 0);
    accept(who);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rsp0", {22'd0, rsp0_valid, rsp0_last, rsp0_data}, 32'd0);
    chk("t5_rom", {22'd0, rom_ce, rom_read_en, rom_addr}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_addr = 8'h20; req1_len = 4'd0;
    wait_acc(who);
    chk("t5_post_grant", who, 1);
    accept(who);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
